// File: rtl/vga_scanout.sv
// -----------------------------------------------------------------------------
// vga_scanout
//
// Generates VGA timing (640x480@60 with the default parameters) from the system
// clock. It hands the current pixel coordinate to the game logic and samples the
// game's colour word. It then drives the VGA pins, with HS/VS delayed by exactly
// the same amount as the colour data.
//
// Ports
//   clk          system clock (50 MHz)
//   reset        synchronous, active-high reset
//   x, y         current pixel coordinate presented to the game
//                (0..H_TOTAL-1, 0..V_TOTAL-1); held for CLK_DIV clks each
//   pixel_in     game colour {R[11:8], B[7:4], G[3:0]} for the coordinate that
//                was presented PIXEL_LATENCY pixel periods earlier; sampled only
//                on the tick clk
//   VGA_R/G/B    4-bit colour pins, forced to 0 outside the visible area
//   VGA_HS/VS    sync pins, active level SYNC_POL
//   vblank       high while y >= V_VISIBLE (follows y, not the delayed pins)
//   frame_start  one-clk pulse as the counters wrap to (0,0)
// -----------------------------------------------------------------------------
module vga_scanout #(
  parameter int H_VISIBLE     = 640,
  parameter int H_FRONT       = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK        = 48,
  parameter int V_VISIBLE     = 480,
  parameter int V_FRONT       = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK        = 33,
  parameter int CLK_DIV       = 2,   // 2..8 clks per pixel period
  parameter int PIXEL_LATENCY = 0,   // 0..3 pixel periods of game pipeline
  parameter bit SYNC_POL      = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [9:0]  x,
  output logic [9:0]  y,
  input  logic [11:0] pixel_in,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        vblank,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEGIN = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEGIN = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  // Per-pixel control word; travels alongside the game's pipeline so that
  // blanking and sync stay aligned with the colour it returns.
  typedef struct packed {
    logic active;
    logic hs_act;
    logic vs_act;
  } ctrl_t;

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  ctrl_t            ctrl_now;
  ctrl_t            ctrl_d;

  assign tick = (div_cnt == DIV_LAST);

  // ---------------------------------------------------------------------------
  // Pixel clock divider and coordinate counters
  // ---------------------------------------------------------------------------
  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would chain x -> y updates within one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt     <= '0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (tick) begin
        div_cnt <= '0;
        if (x == H_LAST) begin
          x <= '0;
          if (y == V_LAST) begin
            y           <= '0;
            frame_start <= 1'b1;
          end else begin
            y <= y + 10'd1;
          end
        end else begin
          x <= x + 10'd1;
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // vblank tracks y directly, so it changes on the same edge as y.
  assign vblank = (y >= V_VIS);

  // ---------------------------------------------------------------------------
  // Control word for the coordinate currently presented
  // ---------------------------------------------------------------------------
  // NOTE: every field gets a default first so no path through the block can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    ctrl_now = '0;
    ctrl_now.active = (x < H_VIS) && (y < V_VIS);
    ctrl_now.hs_act = (x >= HS_BEGIN) && (x < HS_END);
    ctrl_now.vs_act = (y >= VS_BEGIN) && (y < VS_END);
  end

  // ---------------------------------------------------------------------------
  // Delay line matching the game's pixel pipeline (advances on tick only)
  // ---------------------------------------------------------------------------
  generate
    if (PIXEL_LATENCY == 0) begin : g_bypass
      assign ctrl_d = ctrl_now;
    end else begin : g_delay
      ctrl_t stage [PIXEL_LATENCY];

      // NOTE: the stages are cleared on reset (they are a handful of flops, not
      // a RAM) so the pins stay blank until real control words arrive.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < PIXEL_LATENCY; i++) stage[i] <= '0;
        end else if (tick) begin
          stage[0] <= ctrl_now;
          for (int i = 1; i < PIXEL_LATENCY; i++) stage[i] <= stage[i-1];
        end
      end

      assign ctrl_d = stage[PIXEL_LATENCY-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Pin stage: colour and sync registered together on tick
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      VGA_R  <= '0;
      VGA_G  <= '0;
      VGA_B  <= '0;
      VGA_HS <= ~SYNC_POL;
      VGA_VS <= ~SYNC_POL;
    end else if (tick) begin
      VGA_R  <= ctrl_d.active ? pixel_in[11:8] : 4'h0;
      VGA_B  <= ctrl_d.active ? pixel_in[7:4]  : 4'h0;
      VGA_G  <= ctrl_d.active ? pixel_in[3:0]  : 4'h0;
      VGA_HS <= ctrl_d.hs_act ? SYNC_POL : ~SYNC_POL;
      VGA_VS <= ctrl_d.vs_act ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// -----------------------------------------------------------------------------
// tb_vga_scanout
//
// Four instances share one clock and reset:
//   0: default timing, latency 0
//   1: default timing, PIXEL_LATENCY = 2
//   2: CLK_DIV = 4, SYNC_POL = 1
//   3: shrunken timing (24x15 total), latency 1 -- full frames in a short run
// A cycle-level model tracks the coordinate counters. At every tick the bench
// drives the game colour for the coordinate PIXEL_LATENCY periods back and
// pushes the expected pin word to a per-instance scoreboard queue. The queue is
// popped when the pin stage updates.
// -----------------------------------------------------------------------------
module tb_vga_scanout;

  localparam int NI = 4;

  typedef struct {
    int hv, hf, hs, hb, vv, vf, vs, vb, div, lat;
    bit pol;
  } cfg_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       hs;
    logic       vs;
  } pins_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [9:0]  dut_x  [NI];
  logic [9:0]  dut_y  [NI];
  logic [11:0] pix    [NI];
  logic [3:0]  dut_r  [NI];
  logic [3:0]  dut_g  [NI];
  logic [3:0]  dut_b  [NI];
  logic        dut_hs [NI];
  logic        dut_vs [NI];
  logic        dut_vb [NI];
  logic        dut_fs [NI];

  vga_scanout u_def (
    .clk(clk), .reset(reset), .x(dut_x[0]), .y(dut_y[0]), .pixel_in(pix[0]),
    .VGA_R(dut_r[0]), .VGA_G(dut_g[0]), .VGA_B(dut_b[0]),
    .VGA_HS(dut_hs[0]), .VGA_VS(dut_vs[0]), .vblank(dut_vb[0]), .frame_start(dut_fs[0])
  );

  vga_scanout #(.PIXEL_LATENCY(2)) u_lat (
    .clk(clk), .reset(reset), .x(dut_x[1]), .y(dut_y[1]), .pixel_in(pix[1]),
    .VGA_R(dut_r[1]), .VGA_G(dut_g[1]), .VGA_B(dut_b[1]),
    .VGA_HS(dut_hs[1]), .VGA_VS(dut_vs[1]), .vblank(dut_vb[1]), .frame_start(dut_fs[1])
  );

  vga_scanout #(.CLK_DIV(4), .SYNC_POL(1'b1)) u_div (
    .clk(clk), .reset(reset), .x(dut_x[2]), .y(dut_y[2]), .pixel_in(pix[2]),
    .VGA_R(dut_r[2]), .VGA_G(dut_g[2]), .VGA_B(dut_b[2]),
    .VGA_HS(dut_hs[2]), .VGA_VS(dut_vs[2]), .vblank(dut_vb[2]), .frame_start(dut_fs[2])
  );

  vga_scanout #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
    .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .PIXEL_LATENCY(1)
  ) u_small (
    .clk(clk), .reset(reset), .x(dut_x[3]), .y(dut_y[3]), .pixel_in(pix[3]),
    .VGA_R(dut_r[3]), .VGA_G(dut_g[3]), .VGA_B(dut_b[3]),
    .VGA_HS(dut_hs[3]), .VGA_VS(dut_vs[3]), .vblank(dut_vb[3]), .frame_start(dut_fs[3])
  );

  cfg_t  cfg [NI];
  pins_t sbq [NI][$];
  pins_t cur [NI];

  int n_cmp = 0;
  int n_bad = 0;
  int n = 0;          // non-reset clk edges since the last reset edge
  bit armed = 1'b0;

  // Edge-measurement state per instance
  bit hs_prev [NI];
  bit hs_seen [NI];
  int hs_t0   [NI];
  bit vs_prev [NI];
  bit vs_seen [NI];
  int vs_t0   [NI];
  bit vb_prev [NI];
  bit vb_seen [NI];
  int vb_t0   [NI];
  bit fs_seen [NI];
  int fs_t0   [NI];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t n=%0d)", tag, got, exp, $time, n);
    end
  endtask

  function automatic int htot(input cfg_t c);
    return c.hv + c.hf + c.hs + c.hb;
  endfunction

  function automatic int vtot(input cfg_t c);
    return c.vv + c.vf + c.vs + c.vb;
  endfunction

  // Game colour for pixel index q: {x[3:0], y[3:0], 4'hA}
  function automatic logic [11:0] stim_for(input cfg_t c, input int q);
    int qx, qy;
    if (q < 0) return 12'h000;
    qx = q % htot(c);
    qy = (q / htot(c)) % vtot(c);
    return {4'(qx), 4'(qy), 4'hA};
  endfunction

  // Expected pin word once pixel q (negative = pipeline still empty) reaches the pins
  function automatic pins_t pins_for(input cfg_t c, input int q, input logic [11:0] v);
    pins_t p;
    int qx, qy;
    p = '{r: 4'h0, g: 4'h0, b: 4'h0, hs: ~c.pol, vs: ~c.pol};
    if (q >= 0) begin
      qx = q % htot(c);
      qy = (q / htot(c)) % vtot(c);
      if (qx < c.hv && qy < c.vv) begin
        p.r = v[11:8];
        p.b = v[7:4];
        p.g = v[3:0];
      end
      if (qx >= c.hv + c.hf && qx < c.hv + c.hf + c.hs) p.hs = c.pol;
      if (qy >= c.vv + c.vf && qy < c.vv + c.vf + c.vs) p.vs = c.pol;
    end
    return p;
  endfunction

  function automatic string tg(input string name, input int i);
    return $sformatf("%s/u%0d", name, i);
  endfunction

  task automatic check_inst(input int i);
    cfg_t  c;
    int    ht, vt, p, line, frame, q;
    pins_t got;
    bit    hs_now, vs_now, vb_now;
    c     = cfg[i];
    ht    = htot(c);
    vt    = vtot(c);
    p     = n / c.div;
    line  = ht * c.div;
    frame = ht * vt * c.div;

    check(tg("x", i), 32'(dut_x[i]), 32'(p % ht));
    check(tg("y", i), 32'(dut_y[i]), 32'((p / ht) % vt));
    check(tg("vblank", i), 32'(dut_vb[i]), 32'(((p / ht) % vt) >= c.vv));
    check(tg("frame_start", i), 32'(dut_fs[i]), 32'(n > 0 && (n % frame) == 0));

    // The pin stage has just updated on a tick edge: take the next expectation.
    if (n > 0 && (n % c.div) == 0) begin
      check(tg("sb_depth", i), 32'(sbq[i].size()), 32'd1);
      if (sbq[i].size() > 0) cur[i] = sbq[i].pop_front();
      q = p - 1 - c.lat;
      if (i == 0 && q >= 0 && (q % ht) == 5 && ((q / ht) % vt) == 7)
        check("pin_x5_y7_rbg/u0", {20'h0, dut_r[i], dut_b[i], dut_g[i]}, 32'h57A);
    end
    got = '{r: dut_r[i], g: dut_g[i], b: dut_b[i], hs: dut_hs[i], vs: dut_vs[i]};
    check(tg("pins", i), 32'(got), 32'(cur[i]));

    // HS: phase within the line, active width, period
    hs_now = (dut_hs[i] == c.pol);
    if (hs_now && !hs_prev[i]) begin
      check(tg("hs_phase", i), 32'(n % line), 32'((c.hv + c.hf + c.lat + 1) * c.div));
      if (hs_seen[i]) check(tg("hs_period", i), 32'(n - hs_t0[i]), 32'(line));
      hs_seen[i] = 1'b1;
      hs_t0[i]   = n;
    end
    if (!hs_now && hs_prev[i] && hs_seen[i])
      check(tg("hs_width", i), 32'(n - hs_t0[i]), 32'(c.hs * c.div));
    hs_prev[i] = hs_now;

    // VS: phase within the frame, active width, period
    vs_now = (dut_vs[i] == c.pol);
    if (vs_now && !vs_prev[i]) begin
      check(tg("vs_phase", i), 32'(n % frame), 32'(((c.vv + c.vf) * ht + c.lat + 1) * c.div));
      if (vs_seen[i]) check(tg("vs_period", i), 32'(n - vs_t0[i]), 32'(frame));
      vs_seen[i] = 1'b1;
      vs_t0[i]   = n;
    end
    if (!vs_now && vs_prev[i] && vs_seen[i])
      check(tg("vs_width", i), 32'(n - vs_t0[i]), 32'(c.vs * ht * c.div));
    vs_prev[i] = vs_now;

    // vblank: rise point and high time per frame
    vb_now = dut_vb[i];
    if (vb_now && !vb_prev[i]) begin
      check(tg("vblank_rise", i), 32'(n % frame), 32'(c.vv * ht * c.div));
      vb_seen[i] = 1'b1;
      vb_t0[i]   = n;
    end
    if (!vb_now && vb_prev[i] && vb_seen[i])
      check(tg("vblank_width", i), 32'(n - vb_t0[i]), 32'((vt - c.vv) * ht * c.div));
    vb_prev[i] = vb_now;

    // frame_start spacing
    if (dut_fs[i] === 1'b1) begin
      if (fs_seen[i]) check(tg("frame_period", i), 32'(n - fs_t0[i]), 32'(frame));
      fs_seen[i] = 1'b1;
      fs_t0[i]   = n;
    end
  endtask

  task automatic drive_inst(input int i);
    cfg_t c;
    int   p, q;
    c = cfg[i];
    p = n / c.div;
    q = p - c.lat;
    if ((n % c.div) == c.div - 1) begin
      // Next edge is a tick: present the colour for the delayed coordinate.
      pix[i] = stim_for(c, q);
      sbq[i].push_back(pins_for(c, q, pix[i]));
    end else if (i == 0) begin
      pix[i] = stim_for(c, q);
    end else begin
      pix[i] = 12'($urandom);   // must be ignored off-tick
    end
  endtask

  // One clk: sample after the edge, update the model, check, drive next inputs.
  task automatic step();
    @(posedge clk);
    #1;
    if (reset) begin
      n = 0;
      for (int i = 0; i < NI; i++) begin
        sbq[i].delete();
        cur[i]     = pins_for(cfg[i], -1, 12'h000);
        hs_prev[i] = 1'b0; hs_seen[i] = 1'b0;
        vs_prev[i] = 1'b0; vs_seen[i] = 1'b0;
        vb_prev[i] = 1'b0; vb_seen[i] = 1'b0;
        fs_seen[i] = 1'b0;
      end
    end else begin
      n++;
    end
    if (armed) for (int i = 0; i < NI; i++) check_inst(i);
    armed = 1'b1;
    for (int i = 0; i < NI; i++) drive_inst(i);
  endtask

  initial begin
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 0, 1'b0};
    cfg[1] = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 2, 1'b0};
    cfg[2] = '{640, 16, 96, 48, 480, 10, 2, 33, 4, 0, 1'b1};
    cfg[3] = '{16, 2, 4, 2, 8, 2, 2, 3, 2, 1, 1'b0};
    for (int i = 0; i < NI; i++) pix[i] = 12'h000;

    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    // Run to x=300 on the default instance, then reset mid-line for 3 clks.
    for (int k = 0; k < 2000 && n != 600; k++) step();
    check("reach_x300", 32'(n), 32'd600);
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    // Several default lines, a few CLK_DIV=4 lines, many small frames.
    repeat (12000) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Display-side end of the pixel interface that every game module consumes. Generates VGA 640x480@60 timing from the 50 MHz system clock and drives the `x`/`y` pixel coordinates into the game. Samples the game's 12-bit RBG `pixel_in` and drives the DE0 VGA pins (RGB, HS, VS) with sync aligned to the returned pixel data. Also exports `vblank` and `frame_start` so game logic can update state between frames.

## Interface
- `H_VISIBLE`, 640, visible pixels per line (equals `X_DISPLAY` in constants.vh)
- `H_FRONT`, 16, horizontal front porch, pixel periods
- `H_SYNC`, 96, horizontal sync width
- `H_BACK`, 48, horizontal back porch
- `V_VISIBLE`, 480, visible lines (equals `Y_DISPLAY`)
- `V_FRONT`, 10; `V_SYNC`, 2; `V_BACK`, 33, vertical timing, lines
- `CLK_DIV`, 2, clk cycles per pixel period (2 gives 25 MHz from 50 MHz); legal range 2..8
- `PIXEL_LATENCY`, 0, game pipeline depth in pixel periods; legal range 0..3
- `SYNC_POL`, 0, active level of HS/VS
- `clk` in 1: system clock, 50 MHz
- `reset` in 1: synchronous, active-high reset
- `x` out 10: horizontal counter to game, 0..H_TOTAL-1
- `y` out 10: vertical counter to game, 0..V_TOTAL-1
- `pixel_in` in 12: game colour {R,B,G}, 4 bits each, for `x`/`y` as presented PIXEL_LATENCY pixel periods earlier
- `VGA_R`, `VGA_G`, `VGA_B` out 4 each: colour pins
- `VGA_HS`, `VGA_VS` out 1: sync pins
- `vblank` out 1: high while `y` >= V_VISIBLE, undelayed
- `frame_start` out 1: one-clk pulse when counters wrap to (0,0)

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525).
- Divider `div_cnt` counts 0..CLK_DIV-1. `tick` = (`div_cnt` == CLK_DIV-1).
- On `tick`: `x` increments. At H_TOTAL-1, `x` wraps to 0 and `y` increments. At (H_TOTAL-1, V_TOTAL-1), both wrap to 0.
- `x`/`y` are registered and stable for exactly CLK_DIV clks.
- Per-pixel control word is computed from the current `x`/`y`:
  - `active` = `x` < H_VISIBLE and `y` < V_VISIBLE.
  - `hs_act` = `x` in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC).
  - `vs_act` = `y` in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC).
- The control word passes through a PIXEL_LATENCY-deep shift register that advances only on `tick`. With latency 0 it is a bypass.
- Output stage registers on `tick`:
  - RGB = `active_d` ? `pixel_in` : 0. `pixel_in` is unpacked R=[11:8], B=[7:4], G=[3:0].
  - HS = `hs_act_d` ? SYNC_POL : ~SYNC_POL. VS likewise.
- `pixel_in` is sampled only on the `tick` clk. It is don't-care on all other cycles.
- `frame_start` is asserted on the clk where `x`/`y` become (0,0), excluding reset release.

## Timing
- Reset values:
  - `div_cnt` = 0; `x` = `y` = 0.
  - All shift-register stages inactive.
  - RGB = 0; HS = VS = ~SYNC_POL.
  - `vblank` = 0; `frame_start` = 0.
- Reset asserted mid-frame: all of the above apply on the next clk edge. After release, counting restarts at (0,0) and the first `tick` occurs CLK_DIV clks later.
- Output latency: pins reflect the pixel at coordinate (x,y) PIXEL_LATENCY+1 pixel periods after (x,y) was presented. HS/VS/RGB are always mutually aligned.
- Line period is H_TOTAL*CLK_DIV clks (1600). Frame period is V_TOTAL*H_TOTAL*CLK_DIV clks (840 000).
- HS active lasts H_SYNC*CLK_DIV clks (192) per line. VS active lasts V_SYNC*H_TOTAL*CLK_DIV clks (3200).
- `vblank` changes together with `y`. It rises when `y` becomes V_VISIBLE and falls when `y` wraps to 0.

## Test plan
- **Reset mid-line:** reset for 3 clks at x=300 -> next edge x=0, y=0, RGB=0, HS=VS=1. First `x` increment occurs 2 clks after release.
- **Line timing, default params:**
  - HS falls when the pin stage holds x=656, i.e. 1 pixel period after `x` reaches 656.
  - HS stays low 192 clks.
  - HS falling edges are exactly 1600 clks apart.
- **Frame timing:**
  - `frame_start` pulses exactly every 840 000 clks.
  - VS low for 3200 clks beginning when the delayed `y` = 490.
  - `vblank` high for 45*1600 = 72 000 clks per frame.
- **Pixel alignment, latency 0:**
  - Stimulus: `pixel_in` = {x[3:0], y[3:0], 4'hA}.
  - At pin x=5, y=7: R=5, B=7, G=A.
  - At x=640..799: RGB = 0 regardless of `pixel_in`.
- **Pixel alignment, PIXEL_LATENCY=2:**
  - Stimulus: model driving `pixel_in` from `x`/`y` delayed by 2 pixel periods.
  - RGB for x=0 appears together with the first active pin period.
  - HS edge shifts by +2 pixel periods versus latency 0.
- **Parameter sweep, CLK_DIV=4, SYNC_POL=1:**
  - HS high for 384 clks.
  - Line period 3200 clks.
  - `pixel_in` changes on non-tick clks have no effect on RGB.
